// File: rtl/ehl_bmp_reader.sv
// Streaming decoder for 24-bit uncompressed BMP files: parses the 54-byte
// header, skips to the pixel data and emits one RGB pixel per handshake.
module ehl_bmp_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        valid,
  input  logic        ready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SKIP, S_PIX, S_PAD, S_DONE, S_ERR
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt, r_offset, r_width, r_height, r_col, r_row;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_b_buf, r_g_buf;
  logic        r_hdr_bad, r_final;
  logic        r_valid, r_hsync, r_vsync;
  logic [7:0]  r_r, r_g, r_b;
  logic [15:0] r_x, r_y;

  logic        w_s_ready, w_accept, w_start, w_hdr_ok, w_row_end, w_img_end;
  logic [1:0]  w_pad;
  logic [15:0] w_skip_last, w_pad_last;

  // Row stride is 3*width rounded up to 4, so the pad count is width mod 4.
  assign w_pad       = r_width[1:0];
  assign w_pad_last  = {14'd0, w_pad} - 16'd1;
  assign w_skip_last = r_offset - 16'd55;
  assign w_row_end   = (r_col == r_width - 16'd1);
  assign w_img_end   = w_row_end && (r_row == r_height - 16'd1);
  assign w_hdr_ok    = !r_hdr_bad && (r_offset >= 16'd54) &&
                       (r_width != 16'd0) && (r_height != 16'd0);
  assign w_accept    = s_valid && w_s_ready;
  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE ||
                                 r_state == S_ERR);

  // Handshakes: a byte moves when s_valid && s_ready; a pixel moves when
  // valid && ready. valid and the pixel fields hold steady until ready.
  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_HDR;
      S_HDR: begin
        w_s_ready = 1'b1;
        if (s_valid && r_cnt == 16'd53)
          w_next = !w_hdr_ok ? S_ERR : (r_offset > 16'd54 ? S_SKIP : S_PIX);
      end
      S_SKIP: begin
        w_s_ready = 1'b1;
        if (s_valid && r_cnt == w_skip_last) w_next = S_PIX;
      end
      S_PIX: begin
        // Once the final pixel is loaded no more bytes belong to the image.
        w_s_ready = !r_final && (r_byte_idx != 2'd2 || !r_valid || ready);
        if (r_final) begin
          if (!r_valid || ready) w_next = S_DONE;
        end else if (w_s_ready && s_valid && r_byte_idx == 2'd2 &&
                     w_row_end && w_pad != 2'd0) begin
          w_next = S_PAD;
        end
      end
      S_PAD: begin
        w_s_ready = 1'b1;
        if (s_valid && r_cnt == w_pad_last)
          w_next = r_final ? ((!r_valid || ready) ? S_DONE : S_PIX) : S_PIX;
      end
      S_DONE: w_next = start ? S_HDR : S_IDLE;
      S_ERR:  if (start) w_next = S_HDR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0; r_offset <= '0; r_width <= '0; r_height <= '0;
      r_col <= '0; r_row <= '0; r_byte_idx <= '0;
      r_b_buf <= '0; r_g_buf <= '0; r_hdr_bad <= 1'b0; r_final <= 1'b0;
      r_valid <= 1'b0; r_hsync <= 1'b0; r_vsync <= 1'b0;
      r_r <= '0; r_g <= '0; r_b <= '0; r_x <= '0; r_y <= '0;
    end else begin
      if (r_valid && ready) r_valid <= 1'b0;
      if (w_start) begin
        r_cnt <= '0; r_col <= '0; r_row <= '0; r_byte_idx <= '0;
        r_x <= '0; r_y <= '0; r_hdr_bad <= 1'b0; r_final <= 1'b0;
      end else if (w_accept) begin
        unique case (r_state)
          S_HDR: begin
            r_cnt <= (w_next != S_HDR) ? 16'd0 : r_cnt + 16'd1;
            case (r_cnt)
              16'd0:  if (s_data != 8'h42) r_hdr_bad <= 1'b1;
              16'd1:  if (s_data != 8'h4D) r_hdr_bad <= 1'b1;
              16'd10: r_offset[7:0]  <= s_data;
              16'd11: r_offset[15:8] <= s_data;
              16'd18: r_width[7:0]   <= s_data;
              16'd19: r_width[15:8]  <= s_data;
              16'd22: r_height[7:0]  <= s_data;
              16'd23: r_height[15:8] <= s_data;
              16'd28: if (s_data != 8'd24) r_hdr_bad <= 1'b1;
              16'd12, 16'd13, 16'd20, 16'd21, 16'd24, 16'd25,
              16'd29, 16'd30, 16'd31, 16'd32, 16'd33:
                if (s_data != 8'h00) r_hdr_bad <= 1'b1;
              default: ;
            endcase
          end
          S_SKIP, S_PAD: r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
          S_PIX: begin
            unique case (r_byte_idx)
              2'd0: begin r_b_buf <= s_data; r_byte_idx <= 2'd1; end
              2'd1: begin r_g_buf <= s_data; r_byte_idx <= 2'd2; end
              default: begin
                r_byte_idx <= 2'd0;
                r_valid    <= 1'b1;
                r_r <= s_data; r_g <= r_g_buf; r_b <= r_b_buf;
                r_x <= r_col;  r_y <= r_row;
                r_hsync <= w_row_end;
                r_vsync <= w_img_end;
                r_final <= w_img_end;
                if (w_row_end) begin
                  r_col <= '0;
                  r_row <= r_row + 16'd1;
                end else begin
                  r_col <= r_col + 16'd1;
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign s_ready    = w_s_ready;
  assign valid      = r_valid;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign x          = r_x;
  assign y          = r_y;
  assign img_width  = r_width;
  assign img_height = r_height;
  assign busy       = (r_state == S_HDR) || (r_state == S_SKIP) ||
                      (r_state == S_PIX) || (r_state == S_PAD);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ehl_bmp_reader.sv
// Self-checking bench for ehl_bmp_reader: builds BMP files in memory, streams
// them with optional random gaps/backpressure and compares against a model.
module tb_ehl_bmp_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        valid;
  logic        ready = 1'b0;
  logic [7:0]  r, g, b;
  logic        hsync, vsync;
  logic [15:0] x, y, img_width, img_height;
  logic        busy, done, error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fmem[$];
  logic [57:0] exp_q[$];

  ehl_bmp_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .valid(valid), .ready(ready), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put32(input int idx, input logic [31:0] v);
    for (int k = 0; k < 4; k++) fmem[idx + k] = v[8*k +: 8];
  endtask

  // kind: 0 good, 1 bad signature, 2 bpp 32, 3 top-down height
  task automatic build_file(input int w, input int h, input int off,
                            input int kind, input bit rnd_data);
    int stride;
    logic [7:0] seq;
    stride = 3 * w + (w % 4);
    seq = 8'h01;
    fmem.delete();
    for (int i = 0; i < 54; i++) fmem.push_back(8'h00);
    fmem[0] = 8'h42;
    fmem[1] = (kind == 1) ? 8'h58 : 8'h4D;
    put32(2, off + stride * h + 3);
    put32(10, off);
    put32(14, 40);
    put32(18, w);
    put32(22, (kind == 3) ? 32'hFFFF_FFFE : h);
    fmem[26] = 8'd1;
    fmem[28] = (kind == 2) ? 8'd32 : 8'd24;
    for (int i = 54; i < off; i++) fmem.push_back(8'hEE);
    for (int yy = 0; yy < h; yy++) begin
      for (int k = 0; k < 3 * w; k++) begin
        fmem.push_back(rnd_data ? 8'($urandom_range(0, 255)) : seq);
        seq++;
      end
      for (int k = 0; k < w % 4; k++) fmem.push_back(8'hEE);
    end
    for (int k = 0; k < 3; k++) fmem.push_back(8'h5A);
  endtask

  // Reference: pixel (x,y) lives at off + y*stride + 3*x as B,G,R.
  task automatic build_model(input int w, input int h, input int off);
    int stride, idx;
    logic [15:0] xx, yy16;
    stride = 3 * w + (w % 4);
    exp_q.delete();
    for (int yy = 0; yy < h; yy++)
      for (int xi = 0; xi < w; xi++) begin
        idx  = off + yy * stride + 3 * xi;
        xx   = xi[15:0];
        yy16 = yy[15:0];
        exp_q.push_back({fmem[idx + 2], fmem[idx + 1], fmem[idx], xx, yy16,
                         (xi == w - 1), (xi == w - 1) && (yy == h - 1)});
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {valid, s_ready, busy, done, error, hsync, vsync}, 0);
    check({tag, "_rgb"}, {r, g, b}, 0);
    check({tag, "_xy"}, {x, y}, 0);
    check({tag, "_dim"}, {img_width, img_height}, 0);
  endtask

  // driver + monitor: one iteration per clock, inputs driven after negedge
  task automatic run_image(input int w, input int h, input int off,
                           input int kind, input bit rnd, input int abort_px);
    int pos, cyc, n_px, last_acc, last_hs, done_cyc, hdr_cyc, valid_cycles, total;
    bit hold;
    logic [58:0] cur, prev;
    logic [57:0] e;
    build_file(w, h, off, kind, rnd);
    if (kind == 0) build_model(w, h, off);
    total = off + (3 * w + (w % 4)) * h;
    pos = 0; n_px = 0; last_acc = 0; last_hs = 0; done_cyc = -1;
    hdr_cyc = -1; valid_cycles = 0; hold = 1'b0; prev = '0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("busy_after_start", busy, 1);
    check("sready_after_start", s_ready, 1);
    check("error_cleared", error, 0);

    for (cyc = 0; cyc < 4000; cyc++) begin
      s_valid = (pos < fmem.size()) && (!rnd || $urandom_range(0, 3) != 0);
      s_data  = s_valid ? fmem[pos] : 8'h00;
      ready   = !rnd || ($urandom_range(0, 2) != 0);
      #1;
      cur = {valid, r, g, b, x, y, hsync, vsync};
      if (hold) check("hold_stable", cur, prev);
      if (cyc == hdr_cyc + 1 && hdr_cyc >= 0) begin
        check("hdr_error", error, (kind != 0));
        if (kind != 0) check("err_sready", s_ready, 0);
      end
      if (kind != 0 && hdr_cyc >= 0 && cyc == hdr_cyc + 10) break;
      if (done) begin done_cyc = cyc; break; end
      if (s_valid && s_ready) begin
        pos++;
        last_acc = cyc;
        if (pos == 54) hdr_cyc = cyc;
      end
      if (valid) valid_cycles++;
      if (valid && ready) begin
        n_px++;
        last_hs = cyc;
        if (exp_q.size() == 0) check("pixel_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pixel", {r, g, b, x, y, hsync, vsync}, e);
        end
      end
      hold = valid && !ready;
      prev = cur;
      @(negedge clk);
      if (abort_px > 0 && n_px == abort_px) begin
        s_valid = 1'b0; ready = 1'b0;
        reset_n = 1'b0; #1;
        check_reset_outputs("abort_reset");
        #2 reset_n = 1'b1;
        exp_q.delete();
        return;
      end
    end
    s_valid = 1'b0;
    ready   = 1'b0;

    if (kind != 0) begin
      check("err_bytes", pos, 54);
      check("err_no_valid", valid_cycles, 0);
      check("err_sticky", error, 1);
    end else begin
      check("done_seen", (done_cyc >= 0), 1);
      check("pixel_count", n_px, w * h);
      check("bytes_consumed", pos, total);
      check("done_cycle", done_cyc, ((last_hs > last_acc) ? last_hs : last_acc) + 1);
      check("dims", {img_width, img_height}, {w[15:0], h[15:0]});
      check("queue_empty", exp_q.size(), 0);
      @(negedge clk); #1;
      check("done_one_cycle", {done, busy}, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    run_image(4, 2, 54, 0, 1'b0, 0);
    run_image(3, 2, 54, 0, 1'b0, 0);
    run_image(4, 2, 58, 0, 1'b0, 0);
    run_image(5, 3, 54, 0, 1'b1, 0);
    run_image(1, 1, 55, 0, 1'b1, 0);
    run_image(4, 2, 54, 1, 1'b0, 0);
    run_image(4, 2, 54, 0, 1'b0, 0);
    run_image(4, 2, 54, 2, 1'b1, 0);
    run_image(5, 3, 54, 3, 1'b1, 0);
    run_image(5, 3, 54, 0, 1'b1, 0);
    run_image(6, 4, 56, 0, 1'b1, 10);
    run_image(3, 3, 54, 0, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      run_image($urandom_range(1, 7), $urandom_range(1, 4),
                $urandom_range(54, 62), 0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ehl_bmp_reader.md
# ehl_bmp_reader

Synthesizable BMP stream decoder for the VPU path. It consumes a byte stream holding a complete 24-bit uncompressed BMP file and parses the header. It then emits one RGB pixel per handshake, in file order, with line and frame markers. Its output is the pixel/valid/hsync stream that the BMP writer models consume. It is used to replay reference images into VPU pipelines in simulation and on FPGA, fed from ROM/SPI/DMA.

## Interface
- No parameters; image dimensions are 16-bit, fixed by format support.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins parsing a new file. Ignored unless in IDLE, DONE or ERR.
- s_data  in  8  file byte, in file order.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- valid  out  1  pixel valid; held until ready.
- ready  in  1  pixel consumer ready.
- r, g, b  out  8 each  pixel colour; stable while valid && !ready.
- hsync  out  1  qualifies valid; set on the last pixel of each line.
- vsync  out  1  qualifies valid; set on the final pixel of the image.
- x, y  out  16 each  column and row of the current pixel; row 0 is the first row in the file.
- img_width, img_height  out  16 each  dimensions captured from the header.
- busy  out  1  high in HDR, SKIP, PIX and PAD.
- done  out  1  one-cycle pulse when the image completes.
- error  out  1  sticky header error; cleared by start.

## Operation
- FSM states: IDLE, HDR, SKIP, PIX, PAD, DONE, ERR.
- IDLE → HDR on start. Clear byte counter, x, y and error.
- HDR accepts 54 bytes; s_ready = 1. Captured little-endian fields:
  - bytes 0-1 signature, must be 0x42 0x4D;
  - bytes 10-13 data offset, must be ≥ 54 and < 65536;
  - bytes 18-21 width, bytes 22-25 height. Upper 16 bits must be 0 and the value must be nonzero; negative (top-down) height is unsupported and flagged.
  - bytes 28-29 bpp, must be 24;
  - bytes 30-33 compression, must be 0.
- After byte 53 is accepted, any violated check → ERR. Otherwise → SKIP if offset > 54, else PIX.
- SKIP discards (offset − 54) bytes, then → PIX.
- PIX assembles pixels from bytes B, G, R in that order.
  - The R byte loads the output register (r, g, b, x, y, hsync, vsync) and sets valid.
  - s_ready = (byte_idx < 2) || !valid || ready. B and G are buffered internally while the previous pixel drains.
- On the handshake of the last pixel in a row (x == width−1):
  - pad = width[1:0], since row stride is rounded up to 4 bytes. If pad ≠ 0 → PAD, which discards pad bytes and then returns to PIX.
  - x returns to 0 and y increments.
- The pixel with hsync && vsync and its row padding complete the image → DONE. Trailing file bytes are not consumed.
- DONE: done = 1 for one cycle, then → IDLE.
- ERR: s_ready = 0, valid = 0, error = 1. Left only on start (→ HDR) or reset.
- start while busy is ignored. No abort; use reset_n.

## Timing
- Reset values: s_ready 0, valid 0, hsync 0, vsync 0, r/g/b 0, x/y 0, img_width/img_height 0, busy 0, done 0, error 0. FSM → IDLE.
- start sampled high in IDLE: busy and s_ready high the next cycle.
- Header check resolves in the cycle after byte 53 is accepted. error rises in that cycle, or SKIP/PIX is entered.
- Pixel latency: valid rises the cycle after the R byte is accepted.
- Sustained throughput with ready = 1: one byte per cycle, one pixel per 3 cycles. No bubble between pixels.
- ready low with valid high: pixel held; at most 2 further bytes accepted, then s_ready = 0.
- done pulses in the cycle after the final pixel handshake, or after the final pad byte if later.
- s_valid low in any state: the FSM stalls with no side effects.
- reset_n asserted mid-image: all state clears immediately. Any partially delivered image is discarded.

## Test plan
- 4×2 image, offset 54, pixels 0x010203… (B,G,R bytes), ready = 1 → 8 pixels, x/y correct, hsync on x = 3, vsync only on (3,1), done 1 cycle after the 8th pixel, 78 bytes consumed.
- 3×2 image → pad 3 bytes per row; total 54 + 24 bytes consumed; the pad byte values never appear on r/g/b.
- Offset 58 (4 gap bytes of 0xEE) → gap skipped; first pixel equals bytes 58-60.
- Random ready and s_valid toggling on a 5×3 image → pixel sequence identical to the ready = 1 run; r/g/b/x/y stable while valid && !ready.
- Bad signature "BX", bpp = 32, or height = 0xFFFFFFFE → error = 1 after byte 53, s_ready = 0, no valid. A later start with a good file clears error and decodes correctly.
- reset_n pulsed after 10 pixels → all outputs at reset values. A new start decodes a fresh file from byte 0.
